rs_latch_bank: RTL and testbench

- Parametrised, clocked, multi-channel RS storage bank; synchronous successor to the gate-level NOR RS latch.
- Each channel holds one bit, driven by its own set/reset command pair.
- A per-channel stability filter rejects short glitches.
- The illegal S=R=1 condition is resolved by a selectable mode and is counted, so q and q_bar are never equal.
- Sits between raw control strobes and downstream logic that needs clean, sticky flags.

---
 rtl/rs_latch_bank.sv | 108 ++++++++++
 tb/tb_rs_latch_bank.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_latch_bank.sv
// rtl/rs_latch_bank.sv - clocked multi-channel RS storage bank with glitch filter and conflict counter
module rs_latch_bank #(
  parameter int WIDTH = 4,
  parameter int MODE  = 0,
  parameter int FILT  = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] set,
  input  logic [WIDTH-1:0] reset,
  input  logic             cnt_clr,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar,
  output logic [WIDTH-1:0] conflict,
  output logic [CNT_W-1:0] conflict_cnt
);

  generate
    if (MODE < 0 || MODE > 3 || FILT < 1 || FILT > 15 || WIDTH < 1 || WIDTH > 32 || CNT_W < 1) begin : g_bad_param
      $fatal(1, "rs_latch_bank: illegal parameter set");
    end
  endgenerate

  localparam int SW = ((CNT_W > 6) ? CNT_W : 6) + 1;
  localparam logic [3:0] FILT_V = 4'(FILT);

  logic [WIDTH-1:0][1:0] cand, cand_nxt;
  logic [WIDTH-1:0][3:0] stab, stab_nxt;
  logic [WIDTH-1:0]      q_nxt, conf_nxt;
  logic [1:0]            cmd;
  logic                  same, qual, reach;
  logic [5:0]            events;
  logic [SW-1:0]         sum;
  logic [CNT_W-1:0]      cnt_nxt;

  // Stability filter and command application, one channel per iteration
  always_comb begin
    cand_nxt = cand;
    stab_nxt = stab;
    q_nxt    = q;
    conf_nxt = '0;
    cmd      = 2'b00;
    same     = 1'b0;
    qual     = 1'b0;
    reach    = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      cmd  = {set[i], reset[i]};
      same = (cmd == cand[i]);
      if (!same) begin
        cand_nxt[i] = cmd;
        stab_nxt[i] = 4'd1;
      end else if (stab[i] != FILT_V) begin
        stab_nxt[i] = stab[i] + 4'd1;
      end
      qual  = (stab_nxt[i] == FILT_V);
      // "reach" is true only on the edge the count first arrives at FILT
      reach = qual && !(same && stab[i] == FILT_V);
      if (qual) begin
        case (cmd)
          2'b10:   q_nxt[i] = 1'b1;
          2'b01:   q_nxt[i] = 1'b0;
          2'b11: begin
            if (MODE == 0)      q_nxt[i] = 1'b0;
            else if (MODE == 1) q_nxt[i] = 1'b1;
            else if (MODE == 3 && reach) q_nxt[i] = ~q[i];
          end
          default: q_nxt[i] = q[i];
        endcase
      end
      conf_nxt[i] = reach && (cmd == 2'b11);
    end
  end

  always_comb begin
    events = '0;
    for (int i = 0; i < WIDTH; i++) begin
      events = events + 6'(conf_nxt[i]);
    end
    sum = SW'(conflict_cnt) + SW'(events);
    if (sum > SW'({CNT_W{1'b1}})) begin
      cnt_nxt = {CNT_W{1'b1}};
    end else begin
      cnt_nxt = sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cand         <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        stab[i] <= FILT_V;
      end
      q            <= '0;
      q_bar        <= '1;
      conflict     <= '0;
      conflict_cnt <= '0;
    end else begin
      cand         <= cand_nxt;
      stab         <= stab_nxt;
      q            <= q_nxt;
      q_bar        <= ~q_nxt;
      conflict     <= conf_nxt;
      conflict_cnt <= cnt_clr ? '0 : cnt_nxt;
    end
  end

endmodule

// File: tb/tb_rs_latch_bank.sv
// tb/tb_rs_latch_bank.sv - self-checking bench for rs_latch_bank across several parameter sets
module tb_rs_latch_bank;

  localparam int NC = 7;
  // Configurations, index 0 at the LSB: MODE, FILT, CNT_W
  localparam bit [27:0] MODES = {4'd1, 4'd3, 4'd0, 4'd3, 4'd2, 4'd1, 4'd0};
  localparam bit [27:0] FILTS = {4'd4, 4'd3, 4'd2, 4'd1, 4'd1, 4'd1, 4'd1};
  localparam bit [55:0] CWS   = {8'd8, 8'd4, 8'd8, 8'd8, 8'd8, 8'd8, 8'd3};

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [3:0] set_in = '0;
  logic [3:0] rst_in = '0;
  logic       clr = 1'b0;

  logic [3:0] q_a  [NC];
  logic [3:0] qb_a [NC];
  logic [3:0] cf_a [NC];
  logic [7:0] cnt_a[NC];

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NC; g++) begin : g_dut
    localparam int M  = int'(MODES[g*4 +: 4]);
    localparam int F  = int'(FILTS[g*4 +: 4]);
    localparam int CW = int'(CWS[g*8 +: 8]);
    logic [CW-1:0] cc;
    rs_latch_bank #(.WIDTH(4), .MODE(M), .FILT(F), .CNT_W(CW)) u_dut (
      .clk          (clk),
      .reset_n      (rstn),
      .set          (set_in),
      .reset        (rst_in),
      .cnt_clr      (clr),
      .q            (q_a[g]),
      .q_bar        (qb_a[g]),
      .conflict     (cf_a[g]),
      .conflict_cnt (cc)
    );
    assign cnt_a[g] = 8'(cc);
  end

  // Reference model: run length of the current command per channel
  logic [3:0] m_q   [NC];
  logic [3:0] m_conf[NC];
  logic [1:0] m_last[NC][4];
  int         m_run [NC][4];
  int         m_ccnt[NC];

  task automatic model_step();
    for (int c = 0; c < NC; c++) begin
      int f, md, cw, ev;
      f  = int'(FILTS[c*4 +: 4]);
      md = int'(MODES[c*4 +: 4]);
      cw = int'(CWS[c*8 +: 8]);
      if (!rstn) begin
        m_q[c] = '0;
        m_conf[c] = '0;
        m_ccnt[c] = 0;
        for (int i = 0; i < 4; i++) begin
          m_last[c][i] = 2'b00;
          m_run[c][i]  = 1000;
        end
      end else begin
        ev = 0;
        for (int i = 0; i < 4; i++) begin
          logic [1:0] cmd;
          cmd = {set_in[i], rst_in[i]};
          if (cmd == m_last[c][i]) begin
            if (m_run[c][i] < 1000) m_run[c][i]++;
          end else begin
            m_last[c][i] = cmd;
            m_run[c][i]  = 1;
          end
          m_conf[c][i] = (cmd == 2'b11) && (m_run[c][i] == f);
          if (m_run[c][i] >= f) begin
            if (cmd == 2'b10) m_q[c][i] = 1'b1;
            else if (cmd == 2'b01) m_q[c][i] = 1'b0;
            else if (cmd == 2'b11) begin
              if (md == 0) m_q[c][i] = 1'b0;
              else if (md == 1) m_q[c][i] = 1'b1;
              else if (md == 3 && m_run[c][i] == f) m_q[c][i] = ~m_q[c][i];
            end
          end
          ev += int'(m_conf[c][i]);
        end
        if (clr) m_ccnt[c] = 0;
        else if (m_ccnt[c] + ev > (1 << cw) - 1) m_ccnt[c] = (1 << cw) - 1;
        else m_ccnt[c] = m_ccnt[c] + ev;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle(input int n);
    set_in = '0;
    rst_in = '0;
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    set_in = 4'hF;
    step();
    step();
    for (int c = 0; c < NC; c++) begin
      n_cmp++;
      if (q_a[c] !== 4'h0 || qb_a[c] !== 4'hF || cf_a[c] !== 4'h0 || cnt_a[c] !== 8'h0) begin
        n_fail++;
        $display("FAIL reset cfg%0d: q=%h q_bar=%h conflict=%h cnt=%0d, required 0/f/0/0", c, q_a[c], qb_a[c], cf_a[c], cnt_a[c]);
      end
    end
    rstn = 1'b1;
    set_in = 4'h1;
    step();
    n_cmp++;
    if (q_a[4] !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_latency_k: q=%h, required 0", q_a[4]);
    end
    step();
    n_cmp++;
    if (q_a[4] !== 4'h1 || qb_a[4] !== 4'hE) begin
      n_fail++;
      $display("FAIL reset_latency_k1: q=%h q_bar=%h, required 1/e", q_a[4], qb_a[4]);
    end
  endtask

  task automatic test_glitch();
    idle(5);
    set_in = 4'h4;
    step();
    step();
    idle(3);
    n_cmp++;
    if (q_a[5][2] !== 1'b0) begin
      n_fail++;
      $display("FAIL glitch_short: q[2]=%b, required 0", q_a[5][2]);
    end
    set_in = 4'h4;
    step();
    step();
    n_cmp++;
    if (q_a[5][2] !== 1'b0) begin
      n_fail++;
      $display("FAIL glitch_edge2: q[2]=%b, required 0", q_a[5][2]);
    end
    step();
    n_cmp++;
    if (q_a[5][2] !== 1'b1 || qb_a[5][2] !== 1'b0) begin
      n_fail++;
      $display("FAIL glitch_edge3: q[2]=%b q_bar[2]=%b, required 1/0", q_a[5][2], qb_a[5][2]);
    end
  endtask

  task automatic test_modes();
    logic [3:0] exp_q;
    int pulses[4];
    exp_q = 4'b0110;
    set_in = 4'h0;
    rst_in = 4'hF;
    for (int k = 0; k < 5; k++) step();
    set_in = 4'h1;
    rst_in = 4'h0;
    for (int k = 0; k < 5; k++) step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    set_in = 4'h1;
    rst_in = 4'h1;
    for (int c = 0; c < 4; c++) pulses[c] = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      for (int c = 0; c < 4; c++) pulses[c] += int'(cf_a[c][0]);
      if (k == 0) begin
        n_cmp++;
        if (q_a[3][0] !== 1'b0) begin
          n_fail++;
          $display("FAIL mode3_first_edge: q[0]=%b, required 0", q_a[3][0]);
        end
      end
    end
    for (int c = 0; c < 4; c++) begin
      n_cmp++;
      if (q_a[c][0] !== exp_q[c] || qb_a[c][0] !== ~exp_q[c] || pulses[c] != 1 || cnt_a[c] !== 8'd1) begin
        n_fail++;
        $display("FAIL mode%0d: q[0]=%b pulses=%0d cnt=%0d, required q=%b pulses=1 cnt=1", c, q_a[c][0], pulses[c], cnt_a[c], exp_q[c]);
      end
    end
  endtask

  task automatic test_saturation();
    idle(5);
    clr = 1'b1;
    step();
    clr = 1'b0;
    for (int r = 0; r < 3; r++) begin
      set_in = 4'hF;
      rst_in = 4'hF;
      step();
      n_cmp++;
      if (cf_a[0] !== 4'hF || cnt_a[0] !== ((r == 0) ? 8'd4 : 8'd7)) begin
        n_fail++;
        $display("FAIL saturate_round%0d: conflict=%h cnt=%0d, required f/%0d", r, cf_a[0], cnt_a[0], (r == 0) ? 4 : 7);
      end
      idle(1);
    end
  endtask

  task automatic test_clr_collision();
    idle(5);
    clr = 1'b1;
    step();
    clr = 1'b0;
    set_in = 4'hF;
    rst_in = 4'hF;
    step();
    idle(1);
    set_in = 4'h1;
    rst_in = 4'h1;
    step();
    n_cmp++;
    if (cnt_a[0] !== 8'd5) begin
      n_fail++;
      $display("FAIL clr_setup: cnt=%0d, required 5", cnt_a[0]);
    end
    idle(1);
    set_in = 4'h3;
    rst_in = 4'h3;
    clr = 1'b1;
    step();
    clr = 1'b0;
    n_cmp++;
    if (cnt_a[0] !== 8'd0 || cf_a[0] !== 4'h3) begin
      n_fail++;
      $display("FAIL clr_collision: cnt=%0d conflict=%h, required 0/3", cnt_a[0], cf_a[0]);
    end
  endtask

  task automatic test_reset_mid();
    idle(5);
    set_in = 4'h2;
    for (int k = 0; k < 3; k++) step();
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      n_cmp++;
      if (q_a[6][1] !== ((k == 4) ? 1'b1 : 1'b0)) begin
        n_fail++;
        $display("FAIL reset_mid_edge%0d: q[1]=%b, required %b", k, q_a[6][1], (k == 4));
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(2) == 0) begin
          set_in[i] = 1'($urandom);
          rst_in[i] = 1'($urandom);
        end
      end
      clr  = ($urandom_range(15) == 0);
      rstn = ($urandom_range(59) != 0);
      step();
      for (int c = 0; c < NC; c++) begin
        n_cmp++;
        if (q_a[c] !== m_q[c] || qb_a[c] !== ~m_q[c] || cf_a[c] !== m_conf[c] || cnt_a[c] !== 8'(m_ccnt[c])) begin
          n_fail++;
          $display("FAIL random cfg%0d cyc%0d: q=%h q_bar=%h conflict=%h cnt=%0d, required %h/%h/%h/%0d",
                   c, n, q_a[c], qb_a[c], cf_a[c], cnt_a[c], m_q[c], ~m_q[c], m_conf[c], m_ccnt[c]);
        end
      end
    end
    clr = 1'b0;
    rstn = 1'b1;
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_modes();
    test_saturation();
    test_clr_collision();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
